// File: rtl/breath_color_gen.sv
// -----------------------------------------------------------------------------
// breath_color_gen
//
// Breathing-colour source for the addressable LED strip pipeline. A prescaled
// frame-tick counter drives a (CH_W+1)-bit breathing phase; the phase maps to
// a triangular, piecewise-linear intensity. An active colour scheme (flag)
// selects which RGB channels carry that intensity, separately for segment A
// (addr <= SPLIT_ADDR) and segment B (the rest of the strip). Per-pixel
// requests from the serialiser are answered one cycle later from a register.
//
// Optional feature macro: BREATH_GAMMA_EN
//   defined   -> square-law gamma (I*I >> CH_W) is applied to the intensity
//                ahead of the response register; latency is unchanged.
//   undefined -> the triangle intensity is used directly, no multiplier.
//
// Parameters:
//   CH_W       bits per colour channel (phase is CH_W+1 bits)
//   ADDR_W     pixel address width
//   NUM_LEDS   number of valid pixels (0..NUM_LEDS-1)
//   SPLIT_ADDR last address belonging to segment A
//   STEP_DIV   frame ticks per phase step (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse per strip frame
//   auto_cycle   1: scheme increments at each breath wrap; 0: loads color_sel
//   color_sel    externally selected scheme, sampled only at a wrap
//   req_valid    pixel colour request strobe
//   req_addr     requested pixel address
//   color_valid  response strobe, one cycle after req_valid
//   color        response colour {R,G,B}; holds while color_valid is low
//   phase        current breathing phase
//   flag         active colour scheme
//   breath_done  one-cycle pulse following a phase wrap
// -----------------------------------------------------------------------------
module breath_color_gen #(
  parameter int CH_W       = 8,
  parameter int ADDR_W     = 6,
  parameter int NUM_LEDS   = 64,
  parameter int SPLIT_ADDR = 30,
  parameter int STEP_DIV   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                auto_cycle,
  input  logic [2:0]          color_sel,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                color_valid,
  output logic [3*CH_W-1:0]   color,
  output logic [CH_W:0]       phase,
  output logic [2:0]          flag,
  output logic                breath_done
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [CH_W-1:0]  HALF     = CH_W'(1) << (CH_W - 1);
  localparam logic [ADDR_W:0]  ADDR_END = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [ADDR_W:0]  ADDR_SPL = (ADDR_W+1)'(SPLIT_ADDR);

  // Channel-enable masks, ordered {R,G,B}.
  localparam logic [2:0] MASK_R  = 3'b100;
  localparam logic [2:0] MASK_G  = 3'b010;
  localparam logic [2:0] MASK_B  = 3'b001;
  localparam logic [2:0] MASK_RG = 3'b110;
  localparam logic [2:0] MASK_GB = 3'b011;
  localparam logic [2:0] MASK_RB = 3'b101;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [CH_W:0]     r_phase;
  logic [2:0]        r_flag;
  logic              r_breath_done;
  logic              r_color_valid;
  logic [3*CH_W-1:0] r_color;

  logic              w_step;
  logic              w_wrap;
  logic [CH_W-1:0]   w_x;
  logic [CH_W-1:0]   w_level;
  logic [CH_W-1:0]   w_int;
  logic              w_in_range;
  logic              w_seg_a;
  logic [2:0]        w_mask;
  logic [3*CH_W-1:0] w_resp;

  // ---------------------------------------------------------------------------
  // Phase stepping
  // ---------------------------------------------------------------------------
  assign w_step = frame_tick && (r_div_cnt == DIV_LAST);
  assign w_wrap = w_step && (r_phase == '1);

  // ---------------------------------------------------------------------------
  // Intensity
  // ---------------------------------------------------------------------------
  // The falling half mirrors the rising half: M-1-m is simply ~m.
  assign w_x = r_phase[CH_W] ? ~r_phase[CH_W-1:0] : r_phase[CH_W-1:0];

  // The upper segment is x + x/2 - M/2. Only the low CH_W bits are kept, and
  // those are identical whether the sum is formed at CH_W or CH_W+1 bits, so
  // the arithmetic stays at channel width.
  assign w_level = (w_x <= HALF) ? (w_x >> 1) : (w_x + (w_x >> 1) - HALF);

`ifdef BREATH_GAMMA_EN
  logic [2*CH_W-1:0] w_sq;
  assign w_sq  = {{CH_W{1'b0}}, w_level} * {{CH_W{1'b0}}, w_level};
  assign w_int = w_sq[2*CH_W-1:CH_W];
`else
  assign w_int = w_level;
`endif

  // ---------------------------------------------------------------------------
  // Scheme lookup and response colour
  // ---------------------------------------------------------------------------
  assign w_in_range = {1'b0, req_addr} <  ADDR_END;
  assign w_seg_a    = {1'b0, req_addr} <= ADDR_SPL;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_mask = 3'b000;
    case (r_flag)
      3'd0:    w_mask = w_seg_a ? MASK_R  : MASK_RG;
      3'd1:    w_mask = w_seg_a ? MASK_G  : MASK_GB;
      3'd2:    w_mask = w_seg_a ? MASK_B  : MASK_RB;
      3'd3:    w_mask = w_seg_a ? MASK_R  : MASK_GB;
      3'd4:    w_mask = w_seg_a ? MASK_G  : MASK_RB;
      3'd5:    w_mask = w_seg_a ? MASK_B  : MASK_RG;
      3'd6:    w_mask = w_seg_a ? MASK_GB : MASK_RG;
      default: w_mask = w_seg_a ? MASK_RG : MASK_GB;
    endcase
  end

  always_comb begin
    w_resp = '0;
    if (w_in_range) begin
      w_resp = {w_mask[2] ? w_int : {CH_W{1'b0}},
                w_mask[1] ? w_int : {CH_W{1'b0}},
                w_mask[0] ? w_int : {CH_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // State. The response is built from the pre-edge phase and flag, so a
  // request coinciding with a step or wrap sees the old values.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_phase       <= '0;
      r_flag        <= '0;
      r_breath_done <= 1'b0;
      r_color_valid <= 1'b0;
      r_color       <= '0;
    end else begin
      r_breath_done <= w_wrap;
      r_color_valid <= req_valid;
      if (req_valid) begin
        r_color <= w_resp;
      end
      if (frame_tick) begin
        r_div_cnt <= w_step ? '0 : r_div_cnt + DIV_W'(1);
      end
      if (w_step) begin
        r_phase <= r_phase + (CH_W+1)'(1);
      end
      if (w_wrap) begin
        r_flag <= auto_cycle ? r_flag + 3'd1 : color_sel;
      end
    end
  end

  assign color_valid = r_color_valid;
  assign color       = r_color;
  assign phase       = r_phase;
  assign flag        = r_flag;
  assign breath_done = r_breath_done;

endmodule

// File: tb/tb_breath_color_gen.sv
// -----------------------------------------------------------------------------
// tb_breath_color_gen
//
// Two instances share one stimulus stream: dut_a (STEP_DIV=1, NUM_LEDS=60)
// and dut_b (STEP_DIV=4, defaults otherwise). A behavioural model tracks the
// total frame ticks since reset per instance and derives phase, wraps, flag
// and the expected colour from them; a negedge process compares every output
// of both instances every cycle. Directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_breath_color_gen;

  localparam int CH_W = 8;

`ifdef BREATH_GAMMA_EN
  localparam int LVL128 = 16;
  localparam int LVL200 = 115;
`else
  localparam int LVL128 = 64;
  localparam int LVL200 = 172;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        auto_cycle;
  logic [2:0]  color_sel;
  logic        req_valid;
  logic [5:0]  req_addr;

  logic        valid_a, valid_b;
  logic [23:0] color_a, color_b;
  logic [8:0]  phase_a, phase_b;
  logic [2:0]  flag_a, flag_b;
  logic        done_a, done_b;

  always #5 clk = ~clk;

  breath_color_gen #(.STEP_DIV(1), .NUM_LEDS(60)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_cycle(auto_cycle),
    .color_sel(color_sel), .req_valid(req_valid), .req_addr(req_addr),
    .color_valid(valid_a), .color(color_a), .phase(phase_a), .flag(flag_a),
    .breath_done(done_a)
  );

  breath_color_gen #(.STEP_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_cycle(auto_cycle),
    .color_sel(color_sel), .req_valid(req_valid), .req_addr(req_addr),
    .color_valid(valid_b), .color(color_b), .phase(phase_b), .flag(flag_b),
    .breath_done(done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int sd_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int nl_of(input int i);
    return (i == 0) ? 60 : 64;
  endfunction

  // Intensity for a phase in 0..511 following the triangle rule.
  function automatic int level_of(input int ph);
    int m, x, f;
    m = ph % 256;
    x = (ph >= 256) ? (255 - m) : m;
    f = (x <= 128) ? (x / 2) : (x + x / 2 - 128);
    f = f % 256;
`ifdef BREATH_GAMMA_EN
    f = (f * f) / 256;
`endif
    return f;
  endfunction

  function automatic logic [23:0] color_of(input int ph, input int fl, input int addr, input int nl);
    logic [2:0] mk;
    logic [7:0] iv;
    if (addr >= nl) return 24'd0;
    if (addr <= 30) begin
      case (fl)
        0: mk = 3'b100;  1: mk = 3'b010;  2: mk = 3'b001;  3: mk = 3'b100;
        4: mk = 3'b010;  5: mk = 3'b001;  6: mk = 3'b011;  default: mk = 3'b110;
      endcase
    end else begin
      case (fl)
        0: mk = 3'b110;  1: mk = 3'b011;  2: mk = 3'b101;  3: mk = 3'b011;
        4: mk = 3'b101;  5: mk = 3'b110;  6: mk = 3'b110;  default: mk = 3'b011;
      endcase
    end
    iv = 8'(level_of(ph));
    return {mk[2] ? iv : 8'd0, mk[1] ? iv : 8'd0, mk[0] ? iv : 8'd0};
  endfunction

  int          m_tick  [2];
  int          m_flag  [2];
  logic        m_done  [2];
  logic        m_valid [2];
  logic [23:0] m_color [2];
  logic        started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_tick[i]  <= 0;
        m_flag[i]  <= 0;
        m_done[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_color[i] <= 24'd0;
      end else begin
        m_valid[i] <= req_valid;
        if (req_valid)
          m_color[i] <= color_of((m_tick[i] / sd_of(i)) % 512, m_flag[i], int'(req_addr), nl_of(i));
        m_done[i] <= frame_tick && (((m_tick[i] + 1) % (sd_of(i) * 512)) == 0);
        if (frame_tick) begin
          m_tick[i] <= m_tick[i] + 1;
          if (((m_tick[i] + 1) % (sd_of(i) * 512)) == 0)
            m_flag[i] <= auto_cycle ? (m_flag[i] + 1) % 8 : int'(color_sel);
        end
      end
    end
    started <= 1'b1;
  end

  task automatic cmp_inst(input int i, input logic [8:0] ph, input logic [2:0] fl,
                          input logic dn, input logic vl, input logic [23:0] col);
    string p;
    p = (i == 0) ? "a" : "b";
    check({p, ".phase"},       32'(ph),  32'((m_tick[i] / sd_of(i)) % 512));
    check({p, ".flag"},        32'(fl),  32'(m_flag[i]));
    check({p, ".breath_done"}, 32'(dn),  32'(m_done[i]));
    check({p, ".color_valid"}, 32'(vl),  32'(m_valid[i]));
    check({p, ".color"},       32'(col), 32'(m_color[i]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, phase_a, flag_a, done_a, valid_a, color_a);
      cmp_inst(1, phase_b, flag_b, done_b, valid_b, color_b);
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done_a === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge
  // ---------------------------------------------------------------------------
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_tick = 1'b1;
    end
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Returns on the falling edge where the response is visible.
  task automatic req(input int addr, input logic tick);
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 6'(addr);
    frame_tick = tick;
    @(negedge clk);
    req_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic req_pair(input int a0, input int a1);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 6'(a0);
    @(negedge clk);
    req_addr  = 6'(a1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int done_base;

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    auto_cycle = 1'b0;
    color_sel  = 3'd0;
    req_valid  = 1'b0;
    req_addr   = 6'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.phase",       32'(phase_a), 32'd0);
    check("rst.flag",        32'(flag_a),  32'd0);
    check("rst.color",       32'(color_a), 32'd0);
    check("rst.color_valid", 32'(valid_a), 32'd0);
    check("rst.breath_done", 32'(done_a),  32'd0);
    rst_n = 1'b1;

    // Rising half, segment A, scheme 0 -> red only
    ticks(128);
    check("p128.phase", 32'(phase_a), 32'd128);
    req(5, 1'b0);
    check("p128.valid", 32'(valid_a), 32'd1);
    check("p128.color", 32'(color_a), {8'd0, 8'(LVL128), 16'd0});

    // Upper linear segment, segment B, scheme 0 -> red+green
    ticks(72);
    req(40, 1'b0);
    check("p200.color", 32'(color_a), {8'd0, 8'(LVL200), 8'(LVL200), 8'd0});

    // Tick and request together: response uses the pre-step phase
    req(40, 1'b1);
    check("tickreq.color", 32'(color_a), {8'd0, 8'(LVL200), 8'(LVL200), 8'd0});
    check("tickreq.phase", 32'(phase_a), 32'd201);

    // Approach the wrap; color_sel is only sampled on the wrap itself
    color_sel = 3'd2;
    ticks(310);
    check("p511.phase", 32'(phase_a), 32'd511);
    check("p511.flag",  32'(flag_a),  32'd0);
    req(40, 1'b1);
    check("wrap.color",       32'(color_a), 32'd0);
    check("wrap.valid",       32'(valid_a), 32'd1);
    check("wrap.breath_done", 32'(done_a),  32'd1);
    check("wrap.flag",        32'(flag_a),  32'd2);
    check("wrap.phase",       32'(phase_a), 32'd0);
    @(negedge clk);
    check("wrap.done_pulse",  32'(done_a),  32'd0);

    // Falling half, segment B, scheme 2 -> red+blue; later color_sel ignored
    color_sel = 3'd5;
    ticks(311);
    check("p311.flag", 32'(flag_a), 32'd2);
    req(31, 1'b0);
    check("p311.color", 32'(color_a), {8'd0, 8'(LVL200), 8'd0, 8'(LVL200)});

    // Auto-cycling through all schemes with one breath_done per wrap
    do_reset();
    auto_cycle = 1'b1;
    done_base  = done_cnt;
    for (int k = 1; k <= 8; k++) begin
      ticks(256);
      color_sel = 3'(k + 3);
      req_pair(5, 40);
      ticks(256);
      check("auto.flag", 32'(flag_a), 32'(k % 8));
      check("auto.done", 32'(done_a), 32'd1);
    end
    @(negedge clk);
    check("auto.done_count", 32'(done_cnt - done_base), 32'd8);

    // Address range limit on dut_a (NUM_LEDS=60)
    auto_cycle = 1'b0;
    ticks(128);
    req(59, 1'b0);
    check("addr59.color", 32'(color_a), {8'd0, 8'(LVL128), 8'(LVL128), 8'd0});
    req(60, 1'b0);
    check("addr60.color", 32'(color_a), 32'd0);
    check("addr60.valid", 32'(valid_a), 32'd1);

    // Reset while a request is in flight drops the response
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 6'd5;
    rst_n     = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstreq.valid_a", 32'(valid_a), 32'd0);
    check("rstreq.phase_a", 32'(phase_a), 32'd0);
    check("rstreq.valid_b", 32'(valid_b), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
